// File: rtl/video_stream.sv
// Prefetching linear framebuffer reader: issues fixed-size burst reads to the SDRAM
// controller, buffers the returned words in a FIFO and hands them to the display on demand.
module video_stream #(
   parameter int FIFO_AW     = 9,
   parameter int BURST_WORDS = 8,
   parameter int PRI_LEVEL   = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [25:0] baseaddr,
   output logic [25:0] a,
   output logic        req,
   input  logic        ack,
   output logic        pri,
   input  logic [15:0] d,
   input  logic        fill,
   input  logic        rdreq,
   output logic [15:0] q
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int LW    = FIFO_AW + 1;
   localparam int CW    = $clog2(BURST_WORDS + 1);

   logic [15:0]        mem [0:DEPTH-1];
   logic [FIFO_AW-1:0] wr_ptr_reg;
   logic [FIFO_AW-1:0] rd_ptr_reg;
   logic [FIFO_AW-1:0] rd_ptr_next;
   logic [LW-1:0]      level_reg;
   logic [LW-1:0]      level_next;
   logic [LW-1:0]      free_words;
   logic [21:0]        blk_reg;
   logic [CW-1:0]      cnt_reg;
   logic [CW-1:0]      cnt_base;
   logic [15:0]        q_reg;
   logic               req_reg;
   logic               pri_reg;
   logic               start_reg;
   logic               busy_reg;

   logic accept;
   logic burst_open;
   logic beat;
   logic last_beat;
   logic fifo_full;
   logic fifo_empty;
   logic wr_en;
   logic rd_en;
   logic space_ok;
   logic level_low;
   logic can_request;
   logic unused_addr_lsbs;

   assign unused_addr_lsbs = ^baseaddr[3:0];

   assign a   = {blk_reg, 4'b0000};
   assign req = req_reg;
   assign pri = pri_reg;
   assign q   = q_reg;

   // A fill on the very edge that accepts the request already belongs to the new burst.
   assign accept     = req_reg & ack;
   assign burst_open = busy_reg | accept;
   assign beat       = fill & burst_open;
   assign cnt_base   = accept ? '0 : cnt_reg;
   assign last_beat  = beat & (cnt_base == CW'(BURST_WORDS - 1));

   assign fifo_full   = (level_reg == LW'(DEPTH));
   assign fifo_empty  = (level_reg == '0);
   assign wr_en       = beat & ~fifo_full;
   assign rd_en       = rdreq & ~fifo_empty;
   assign rd_ptr_next = rd_ptr_reg + FIFO_AW'(rd_en);
   assign level_next  = level_reg + LW'(wr_en) - LW'(rd_en);

   // Requests are only raised with no burst outstanding, so free space already
   // accounts for every word that can still arrive.
   assign free_words  = LW'(DEPTH) - level_reg;
   assign space_ok    = (free_words >= LW'(BURST_WORDS));
   assign level_low   = (level_reg < LW'(PRI_LEVEL));
   assign can_request = enable & ~start_reg & ~busy_reg & space_ok;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_reg] <= d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blk_reg    <= '0;
         start_reg  <= 1'b1;
         req_reg    <= 1'b0;
         pri_reg    <= 1'b0;
         busy_reg   <= 1'b0;
         cnt_reg    <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         q_reg      <= '0;
      end else begin
         if (start_reg) begin
            blk_reg   <= baseaddr[25:4];
            start_reg <= 1'b0;
         end else if (accept) begin
            blk_reg <= blk_reg + 22'd1;
         end

         // Once raised, a request is held until acknowledged.
         if (req_reg) begin
            if (ack) begin
               req_reg <= 1'b0;
               pri_reg <= 1'b0;
            end else begin
               pri_reg <= level_low;
            end
         end else if (can_request) begin
            req_reg <= 1'b1;
            pri_reg <= level_low;
         end

         if (beat) begin
            cnt_reg  <= cnt_base + CW'(1);
            busy_reg <= ~last_beat;
         end else if (accept) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
         end

         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
         rd_ptr_reg <= rd_ptr_next;
         level_reg  <= level_next;

         // Show-ahead head register; bypass the incoming word when it lands in an empty FIFO.
         if (level_next != '0) begin
            if (level_reg == LW'(rd_en))
               q_reg <= d;
            else
               q_reg <= mem[rd_ptr_next];
         end
      end
   end

endmodule

// File: tb/tb_video_stream.sv
// Directed self-checking bench for video_stream: startup, burst fetch, FIFO fill/drain,
// enable gating, underflow/stray data and reset in the middle of a burst.
module tb_video_stream;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [25:0] baseaddr;
   logic [25:0] a;
   logic        req;
   logic        ack;
   logic        pri;
   logic [15:0] d;
   logic        fill;
   logic        rdreq;
   logic [15:0] q;

   int n_checks = 0;
   int n_fail   = 0;

   video_stream dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .baseaddr (baseaddr),
      .a        (a),
      .req      (req),
      .ack      (ack),
      .pri      (pri),
      .d        (d),
      .fill     (fill),
      .rdreq    (rdreq),
      .q        (q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic send_burst(input logic [15:0] first);
      for (int i = 0; i < 8; i++) begin
         d    = first + 16'(i);
         fill = 1'b1;
         tick();
      end
      fill = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [15:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         check(tag, {16'h0, q}, {16'h0, first + 16'(i)});
         rdreq = 1'b1;
         tick();
      end
      rdreq = 1'b0;
   endtask

   initial begin
      int bursts;
      reset_n  = 1'b0;
      enable   = 1'b1;
      baseaddr = 26'h0123450;
      ack      = 1'b0;
      d        = 16'h0;
      fill     = 1'b0;
      rdreq    = 1'b0;
      tick();
      tick();
      check("reset_req", {31'h0, req}, 32'h0);
      check("reset_pri", {31'h0, pri}, 32'h0);
      check("reset_a",   {6'h0, a},    32'h0);
      check("reset_q",   {16'h0, q},   32'h0);

      // Startup: address loads on the first edge, request on the second.
      reset_n = 1'b1;
      tick();
      check("start_a",   {6'h0, a},    32'h0123450);
      check("start_req", {31'h0, req}, 32'h0);
      tick();
      check("first_req", {31'h0, req}, 32'h1);
      check("first_pri", {31'h0, pri}, 32'h1);

      do_ack();
      check("ack_req",   {31'h0, req}, 32'h0);
      check("ack_pri",   {31'h0, pri}, 32'h0);
      check("ack_a",     {6'h0, a},    32'h0123460);
      send_burst(16'h1000);
      check("burst_q",   {16'h0, q},   32'h1000);
      check("burst_req_gap", {31'h0, req}, 32'h0);
      tick();
      check("next_req",  {31'h0, req}, 32'h1);
      check("next_pri",  {31'h0, pri}, 32'h1);
      check("next_a",    {6'h0, a},    32'h0123460);
      pop_check("pop1", 16'h1000, 8);
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      check("empty_pop_q", {16'h0, q}, 32'h1007);

      // Fill the whole FIFO without reading.
      bursts = 0;
      while (req && bursts < 70) begin
         check("fill_a",   {6'h0, a},    32'h0123460 + 32'(bursts * 16));
         check("fill_pri", {31'h0, pri}, {31'h0, (bursts * 8) < 64});
         do_ack();
         send_burst(16'h2000 + 16'(bursts * 8));
         tick();
         bursts++;
      end
      check("fill_bursts", bursts, 64);
      tick();
      tick();
      check("full_req", {31'h0, req}, 32'h0);
      check("full_a",   {6'h0, a},    32'h0123860);
      pop_check("pop_full", 16'h2000, 512);
      check("drained_req", {31'h0, req}, 32'h1);
      check("drained_pri", {31'h0, pri}, 32'h1);

      // enable drops while a request is pending.
      enable = 1'b0;
      tick();
      check("hold_req", {31'h0, req}, 32'h1);
      do_ack();
      send_burst(16'h3000);
      tick();
      tick();
      tick();
      check("noen_req", {31'h0, req}, 32'h0);
      check("noen_q",   {16'h0, q},   32'h3000);
      enable = 1'b1;
      tick();
      check("reen_req", {31'h0, req}, 32'h1);
      check("reen_a",   {6'h0, a},    32'h0123870);
      pop_check("pop_en", 16'h3000, 8);

      // Underflow and stray fill with nothing in flight.
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      check("uflow_q", {16'h0, q}, 32'h3007);
      d    = 16'hdead;
      fill = 1'b1;
      tick();
      fill = 1'b0;
      check("stray_q", {16'h0, q}, 32'h3007);
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      check("stray_pop_q", {16'h0, q}, 32'h3007);

      // Reset in the middle of a burst.
      do_ack();
      check("mid_a", {6'h0, a}, 32'h0123880);
      for (int i = 0; i < 3; i++) begin
         d    = 16'h4000 + 16'(i);
         fill = 1'b1;
         tick();
      end
      fill = 1'b0;
      check("mid_q", {16'h0, q}, 32'h4000);
      reset_n  = 1'b0;
      baseaddr = 26'h2000000;
      #1;
      check("rst_req", {31'h0, req}, 32'h0);
      check("rst_q",   {16'h0, q},   32'h0);
      check("rst_a",   {6'h0, a},    32'h0);
      tick();
      reset_n = 1'b1;
      ack     = 1'b1;
      d       = 16'h5555;
      fill    = 1'b1;
      tick();
      ack = 1'b0;
      check("rst2_a",   {6'h0, a},    32'h2000000);
      check("rst2_req", {31'h0, req}, 32'h0);
      tick();
      fill = 1'b0;
      check("rst2_req1", {31'h0, req}, 32'h1);
      check("late_q",    {16'h0, q},   32'h0);
      do_ack();
      check("rst2_a_next", {6'h0, a}, 32'h2000010);
      send_burst(16'h6000);
      check("rst2_q", {16'h0, q}, 32'h6000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/video_stream.md
Name: video_stream

Overview:
- Prefetching linear framebuffer reader for the RTG display path.
- Issues 8-word (16-byte) burst read requests to the SDRAM controller starting at a programmable base address.
- Buffers returned words in an internal FIFO and delivers them one word per display read strobe.
- Asserts a priority flag when the FIFO runs low, so display fetches win arbitration over CPU traffic.

Parameters:
- FIFO_AW, 9: log2 of FIFO depth in 16-bit words (512 words).
- BURST_WORDS, 8: words returned per request. The address advances 16 bytes per burst.
- PRI_LEVEL, 64: FIFO fill level (words) below which pri is asserted.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset. Clears FIFO and request state.
- enable  input  1  permits new fetch requests when high.
- baseaddr  input  26  byte address of frame start, 16-byte aligned. Bits [3:0] are ignored and treated as 0.
- a  output  26  byte address of the current/next burst request. Bits [3:0] are always 0.
- req  output  1  burst request to SDRAM controller.
- ack  input  1  one-cycle pulse: current request accepted.
- pri  output  1  high-priority qualifier for req.
- d  input  16  burst read data.
- fill  input  1  one-cycle strobe: d holds a valid word of the accepted burst.
- rdreq  input  1  display pop strobe.
- q  output  16  word at FIFO head (show-ahead).

Behaviour:
- Reset values (async, while reset_n=0): req=0, pri=0, q=0, a=0, FIFO empty, burst word counter=0, in-flight flag=0, "start" flag set.
- First rising edge after reset release with start set: a <= {baseaddr[25:4],4'b0}, start cleared. req is never asserted on this edge.
- Request: req rises when all of the following hold:
  - enable=1, start clear, no burst in flight;
  - FIFO free space >= BURST_WORDS.
- While req=1, a is held stable. pri = req AND (FIFO level < PRI_LEVEL), registered with req. pri is always 0 when req=0.
- On ack=1 while req=1:
  - next edge: req<=0, pri<=0, in-flight<=1, word counter<=0;
  - a <= a+16, wrapping modulo 2^26.
- ack while req=0 is ignored.
- Each fill=1 while in flight:
  - writes d into FIFO tail and increments the word counter;
  - after the BURST_WORDS-th word, in-flight clears.
  - The next req may assert on the edge after in-flight clears, if conditions hold.
- fill with no burst in flight (e.g. stale data after reset) is discarded.
- fill may arrive on the same edge as ack or any later edge. Consecutive fill strobes are back-to-back capable.
- enable falling mid-request: an asserted req stays until ack (a request is never withdrawn). The in-flight burst completes normally. No new requests follow.
- Space reservation: free-space check counts words of the in-flight burst as already occupied, so the FIFO never overflows. A fill into a full FIFO cannot occur; if it does, the word is dropped.
- Read: q always shows the head word when the FIFO is non-empty.
  - rdreq=1 with FIFO non-empty pops; q updates to the next word by the following edge (one-cycle latency).
  - rdreq with FIFO empty has no effect; q holds its last value (underflow protected).
  - Simultaneous write and pop on the same edge are both performed; level is unchanged.
- Level counter width FIFO_AW+1; full = level == 2^FIFO_AW.
- Reset asserted mid-burst: everything clears immediately. The next frame starts from baseaddr sampled after release.

Test Plan:
- Reset, baseaddr=0x0123450, enable=1 → a=0x0123450, req=1 on 2nd edge after release, pri=1 (FIFO empty).
- Ack, then 8 fills d=0x1000..0x1007 → a=0x0123460. q=0x1000; 8 rdreq pops return 0x1000..0x1007 in order; level returns to 0.
- Fill FIFO without reads → req stops when free space <8. Exactly 512 words are stored, then 512 pops match the write order; pri is 0 once level >= 64.
- enable=0 while req=1 → req holds until ack, the 8 fills are accepted, no further req. enable=1 → req resumes at a+16.
- rdreq on empty FIFO, then stray fill with nothing in flight → q unchanged, level stays 0.
- Reset pulse mid-burst after 3 fills, baseaddr changed to 0x2000000 → FIFO empty, q=0, next req at a=0x2000000; late fills before the new ack are discarded.
